// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for decode and hazard logic.
// REGFILE_BYPASS_EN selects write-through forwarding on the read ports.
package regfile_pkg;

   localparam int DEFAULT_DATA_WIDTH = 4;
   localparam int DEFAULT_ADDR_WIDTH = 3;

   // Lets other pipeline stages see which forwarding build they are paired with.
`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/reg_cell.sv
// One register-file entry: a data word plus its valid bit.
// Async active-low reset, sync clear (wins over enable), sync load.
module reg_cell #(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  valid
);

   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (clr) begin
         data_d  = '0;
         valid_d = 1'b0;
      end else if (en) begin
         data_d  = d;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign q     = data_q;
   assign valid = valid_q;

endmodule

// File: rtl/reg_file_param.sv
// General register file: one write port, two combinational read ports, per-entry valid.
// Optional write-through forwarding is built when REGFILE_BYPASS_EN is defined.
module reg_file_param
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter bit ZERO_REG   = 1'b0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CLR,
   input  logic                  WE,
   input  logic [ADDR_WIDTH-1:0] WADDR,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic [ADDR_WIDTH-1:0] RADDR_A,
   output logic [DATA_WIDTH-1:0] RDATA_A,
   output logic                  RVALID_A,
   input  logic [ADDR_WIDTH-1:0] RADDR_B,
   output logic [DATA_WIDTH-1:0] RDATA_B,
   output logic                  RVALID_B
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DEPTH-1:0]      wr_en;
   logic [DATA_WIDTH-1:0] cell_data [DEPTH];
   logic [DEPTH-1:0]      cell_valid;

   // Hardwired-zero entry 0 never accepts a write.
   always_comb begin
      wr_en = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wr_en[i] = WE && (WADDR == ADDR_WIDTH'(i));
      end
      if (ZERO_REG) begin
         wr_en[0] = 1'b0;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      if (ZERO_REG && g == 0) begin : g_zero
         assign cell_data[g]  = '0;
         assign cell_valid[g] = 1'b1;
      end else begin : g_cell
         reg_cell #(
            .DATA_WIDTH(DATA_WIDTH)
         ) u_cell (
            .clk  (CLK),
            .rst_n(RST),
            .clr  (CLR),
            .en   (wr_en[g]),
            .d    (WDATA),
            .q    (cell_data[g]),
            .valid(cell_valid[g])
         );
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic fwd_ok, fwd_a, fwd_b;

   // Forward only a write that will actually land on this edge.
   assign fwd_ok = WE && !CLR && RST;
   assign fwd_a  = fwd_ok && (RADDR_A == WADDR) && !(ZERO_REG && RADDR_A == '0);
   assign fwd_b  = fwd_ok && (RADDR_B == WADDR) && !(ZERO_REG && RADDR_B == '0);

   always_comb begin
      RDATA_A  = fwd_a ? WDATA : cell_data[RADDR_A];
      RVALID_A = fwd_a ? 1'b1  : cell_valid[RADDR_A];
      RDATA_B  = fwd_b ? WDATA : cell_data[RADDR_B];
      RVALID_B = fwd_b ? 1'b1  : cell_valid[RADDR_B];
   end
`else
   always_comb begin
      RDATA_A  = cell_data[RADDR_A];
      RVALID_A = cell_valid[RADDR_A];
      RDATA_B  = cell_data[RADDR_B];
      RVALID_B = cell_valid[RADDR_B];
   end
`endif

endmodule
